rz_decoder: RTL and testbench

Single-wire return-to-zero (WS2812-style) line receiver. It samples the serial LED data line, classifies each high pulse as a 0 or 1 by its width, and packs the bits MSB-first into 24-bit colour words. It flags frame boundaries (the long low latch gap) and timing violations. It sits beside the LED transmit path for loopback checking of the encoder output, and for capturing daisy-chain output from a strip.

---
 rtl/rz_decoder.sv | 190 +++++++++++++++++++
 tb/tb_rz_decoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rz_decoder.sv
// rz_decoder: single-wire return-to-zero (WS2812-style) line receiver.
// Classifies each high pulse by width, packs bits MSB-first into 24-bit
// words, and flags frame ends (long low gap) and timing violations.
module rz_decoder #(
  parameter int unsigned T_MIN_HIGH  = 5,
  parameter int unsigned T_THRESH    = 26,
  parameter int unsigned T_MAX_HIGH  = 60,
  parameter int unsigned T_RESET_CYC = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rz_in,
  output logic [23:0] rgb_out,
  output logic        rgb_valid,
  output logic [7:0]  pix_idx,
  output logic        frame_done,
  output logic [7:0]  frame_len,
  output logic        err
);

  localparam logic [15:0] MIN_W = 16'(T_MIN_HIGH);
  localparam logic [15:0] THR_W = 16'(T_THRESH);
  localparam logic [15:0] MAX_W = 16'(T_MAX_HIGH);
  localparam logic [15:0] RST_W = 16'(T_RESET_CYC);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_STUCK} state_e;

  state_e      state_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic [1:0]  warm_q;
  logic        fresh_q;
  logic [15:0] hi_cnt_q, lo_cnt_q;
  logic [4:0]  bit_cnt_q;
  logic [7:0]  pix_cnt_q;
  logic [22:0] shift_q;
  logic [23:0] word_q;
  logic        word_pend_q;
  logic [23:0] rgb_q;
  logic        rgb_valid_q;
  logic [7:0]  pix_idx_q;
  logic        frame_done_q;
  logic [7:0]  frame_len_q;
  logic        err_q;

  logic        rise, fall, bit_val;
  logic [15:0] hi_inc, lo_inc;
  logic [7:0]  pix_inc;

  always_comb begin
    rise    = sync2_q & ~sync3_q;
    fall    = sync3_q & ~sync2_q;
    bit_val = (hi_cnt_q >= THR_W);
    hi_inc  = (hi_cnt_q == '1) ? hi_cnt_q : hi_cnt_q + 16'd1;
    lo_inc  = (lo_cnt_q == '1) ? lo_cnt_q : lo_cnt_q + 16'd1;
    pix_inc = (pix_cnt_q == '1) ? pix_cnt_q : pix_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      warm_q  <= '0;
    end else begin
      sync1_q <= rz_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      warm_q  <= {warm_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fresh_q      <= 1'b1;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_pend_q  <= 1'b0;
      rgb_q        <= '0;
      rgb_valid_q  <= 1'b0;
      pix_idx_q    <= '0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rgb_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;

      // A completed word is held one extra cycle before presentation.
      if (word_pend_q) begin
        rgb_q       <= word_q;
        pix_idx_q   <= pix_cnt_q;
        rgb_valid_q <= 1'b1;
        pix_cnt_q   <= pix_inc;
        word_pend_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          // Once the synchronizer holds real pin data, a line already high
          // is treated as stuck so no truncated pulse is decoded.
          if (fresh_q) begin
            if (warm_q[1]) begin
              fresh_q <= 1'b0;
              if (sync2_q) state_q <= S_STUCK;
            end
          end else if (rise) begin
            state_q  <= S_HIGH;
            hi_cnt_q <= 16'd1;
          end
        end

        S_HIGH: begin
          if (hi_cnt_q >= MAX_W) begin
            err_q     <= 1'b1;
            bit_cnt_q <= '0;
            if (fall) begin
              state_q  <= S_LOW;
              lo_cnt_q <= 16'd1;
            end else begin
              state_q <= S_STUCK;
            end
          end else if (fall) begin
            state_q  <= S_LOW;
            lo_cnt_q <= 16'd1;
            if (hi_cnt_q < MIN_W) begin
              err_q <= 1'b1;
            end else begin
              shift_q <= {shift_q[21:0], bit_val};
              if (bit_cnt_q == 5'd23) begin
                word_q      <= {shift_q, bit_val};
                word_pend_q <= 1'b1;
                bit_cnt_q   <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end else begin
            hi_cnt_q <= hi_inc;
          end
        end

        S_LOW: begin
          // Frame end wins over a simultaneous rise; the rise still opens
          // the next pulse so a gap of exactly the reset length loses no bit.
          if (lo_cnt_q >= RST_W) begin
            frame_done_q <= 1'b1;
            frame_len_q  <= pix_cnt_q;
            if (bit_cnt_q != '0) err_q <= 1'b1;
            pix_cnt_q <= '0;
            bit_cnt_q <= '0;
            if (rise) begin
              state_q  <= S_HIGH;
              hi_cnt_q <= 16'd1;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (rise) begin
            state_q  <= S_HIGH;
            hi_cnt_q <= 16'd1;
          end else begin
            lo_cnt_q <= lo_inc;
          end
        end

        S_STUCK: begin
          if (fall) begin
            state_q  <= S_LOW;
            lo_cnt_q <= 16'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rgb_out    = rgb_q;
  assign rgb_valid  = rgb_valid_q;
  assign pix_idx    = pix_idx_q;
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rz_decoder.sv
// Bench for rz_decoder: a run-length model of the pin predicts every
// output cycle by cycle; directed scenarios add literal expectations.
module tb_rz_decoder;

  localparam int T_MIN = 5;
  localparam int T_THR = 26;
  localparam int T_MAX = 60;
  localparam int T_RST = 2500;
  localparam int GAP   = T_RST + 10;
  localparam int LO    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rz_in = 1'b0;
  logic [23:0] rgb_out;
  logic        rgb_valid;
  logic [7:0]  pix_idx;
  logic        frame_done;
  logic [7:0]  frame_len;
  logic        err;

  rz_decoder #(
    .T_MIN_HIGH (T_MIN),
    .T_THRESH   (T_THR),
    .T_MAX_HIGH (T_MAX),
    .T_RESET_CYC(T_RST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rz_in     (rz_in),
    .rgb_out   (rgb_out),
    .rgb_valid (rgb_valid),
    .pix_idx   (pix_idx),
    .frame_done(frame_done),
    .frame_len (frame_len),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: pin run lengths -> scheduled outputs ----------
  int          mc = 0;
  int          sl, sl3;
  logic        s_valid [8];
  logic [23:0] s_rgb   [8];
  logic [7:0]  s_idx   [8];
  logic        s_done  [8];
  logic [7:0]  s_len   [8];
  logic        s_err   [8];
  logic        c_valid = 1'b0, c_done = 1'b0, c_err = 1'b0;
  logic [23:0] h_rgb = '0;
  logic [7:0]  h_idx = '0, h_len = '0;
  logic        prev_p;
  int          hrun, lrun, bits, npix;
  bit          stuck, in_frame;
  logic [23:0] acc;
  logic [23:0] mdl_words[$];

  initial forever begin
    @(posedge clk);
    mc++;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        s_valid[i] = 1'b0; s_done[i] = 1'b0; s_err[i] = 1'b0;
        s_rgb[i] = '0; s_idx[i] = '0; s_len[i] = '0;
      end
      c_valid = 1'b0; c_done = 1'b0; c_err = 1'b0;
      h_rgb = '0; h_idx = '0; h_len = '0;
      prev_p = 1'b0; hrun = 0; lrun = 0; bits = 0; npix = 0;
      stuck = 1'b0; in_frame = 1'b0; acc = '0;
    end else begin
      sl = mc % 8;
      c_valid = s_valid[sl];
      c_done  = s_done[sl];
      c_err   = s_err[sl];
      if (s_valid[sl]) begin h_rgb = s_rgb[sl]; h_idx = s_idx[sl]; end
      if (s_done[sl]) h_len = s_len[sl];
      s_valid[sl] = 1'b0; s_done[sl] = 1'b0; s_err[sl] = 1'b0;
      sl3 = (mc + 3) % 8;
      if (rz_in) begin
        if (!prev_p) begin
          hrun = 1; stuck = 1'b0; in_frame = 1'b1;
        end else if (hrun < 65535) begin
          hrun++;
        end
        if (hrun == T_MAX && !stuck) begin
          stuck = 1'b1; bits = 0; s_err[sl3] = 1'b1;
        end
      end else begin
        if (prev_p) begin
          if (!stuck) begin
            if (hrun < T_MIN) begin
              s_err[(mc + 2) % 8] = 1'b1;
            end else begin
              acc = {acc[22:0], hrun >= T_THR};
              bits++;
              if (bits == 24) begin
                s_valid[sl3] = 1'b1; s_rgb[sl3] = acc; s_idx[sl3] = npix[7:0];
                mdl_words.push_back(acc);
                if (npix < 255) npix++;
                bits = 0;
              end
            end
          end
          stuck = 1'b0;
          lrun = 1;
        end else if (lrun < 65535) begin
          lrun++;
        end
        if (in_frame && lrun == T_RST) begin
          s_done[sl3] = 1'b1; s_len[sl3] = npix[7:0];
          if (bits != 0) s_err[sl3] = 1'b1;
          npix = 0; bits = 0; in_frame = 1'b0;
        end
      end
      prev_p = rz_in;
    end
  end

  // ---------------- per-cycle compare plus event logs -------------------
  logic [23:0] q_words[$];
  logic [7:0]  q_idx[$];
  logic [7:0]  q_lens[$];
  int          n_err = 0, n_err_done = 0;

  initial forever begin
    @(negedge clk);
    if (rgb_valid === 1'b1) begin q_words.push_back(rgb_out); q_idx.push_back(pix_idx); end
    if (frame_done === 1'b1) begin
      q_lens.push_back(frame_len);
      if (err === 1'b1) n_err_done++;
    end
    if (err === 1'b1) n_err++;
    check("cycle{valid,done,err,rgb,idx,len}",
          64'({rgb_valid, frame_done, err, rgb_out, pix_idx, frame_len}),
          64'({c_valid, c_done, c_err, h_rgb, h_idx, h_len}));
  end

  function automatic logic [23:0] word_at(input int i);
    return (i >= 0 && i < q_words.size()) ? q_words[i] : 24'hxxxxxx;
  endfunction
  function automatic logic [7:0] idx_at(input int i);
    return (i >= 0 && i < q_idx.size()) ? q_idx[i] : 8'hxx;
  endfunction
  function automatic logic [7:0] len_at(input int i);
    return (i >= 0 && i < q_lens.size()) ? q_lens[i] : 8'hxx;
  endfunction
  function automatic logic [23:0] mdl_last();
    return (mdl_words.size() > 0) ? mdl_words[mdl_words.size() - 1] : 24'hxxxxxx;
  endfunction

  // ---------------- stimulus ----------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    rz_in = 1'b1;
    repeat (hi) @(negedge clk);
    rz_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] w, input int msb, input int count,
                           input int hi1, input int lo1, input int hi0, input int lo0);
    for (int k = 0; k < count; k++) begin
      if (w[msb - k]) pulse(hi1, lo1);
      else            pulse(hi0, lo0);
    end
  endtask

  task automatic clear_logs();
    q_words.delete(); q_idx.delete(); q_lens.delete(); mdl_words.delete();
    n_err = 0; n_err_done = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rgb_out"},    64'(rgb_out),    64'd0);
    check({tag, "_pix_idx"},    64'(pix_idx),    64'd0);
    check({tag, "_frame_len"},  64'(frame_len),  64'd0);
    check({tag, "_rgb_valid"},  64'(rgb_valid),  64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_err"},        64'(err),        64'd0);
  endtask

  int bad;

  initial begin
    rst = 1'b1; rz_in = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(10);

    // Single word with the nominal WS2812 timing.
    clear_logs();
    send_bits(24'hFF0000, 23, 24, 35, 28, 18, 45);
    idle(GAP);
    check("single_count", 64'(q_words.size()), 64'd1);
    check("single_word",  64'(word_at(0)),     64'hFF0000);
    check("single_idx",   64'(idx_at(0)),      64'd0);
    check("single_len",   64'(len_at(0)),      64'd1);
    check("single_err",   64'(n_err),          64'd0);
    check("single_model", 64'(mdl_last()),     64'hFF0000);

    // 60 counting words then a word at the 26/25 threshold edge.
    clear_logs();
    for (int i = 0; i < 60; i++) send_bits(24'(i), 23, 24, 35, 6, 18, 6);
    send_bits(24'hAAAAAA, 23, 24, 26, 6, 25, 6);
    idle(GAP);
    bad = 0;
    for (int i = 0; i < q_idx.size(); i++) if (q_idx[i] !== 8'(i)) bad++;
    check("multi_count",   64'(q_words.size()), 64'd61);
    check("multi_idx_run", 64'(bad),            64'd0);
    check("multi_word59",  64'(word_at(59)),    64'h00003B);
    check("multi_last",    64'(word_at(60)),    64'hAAAAAA);
    check("multi_lastidx", 64'(idx_at(60)),     64'd60);
    check("multi_len",     64'(len_at(0)),      64'd61);
    check("multi_err",     64'(n_err),          64'd0);
    check("multi_model",   64'(mdl_last()),     64'hAAAAAA);

    // Partial word closed by the gap, then a fresh word.
    clear_logs();
    send_bits(24'hABC000, 23, 10, 35, LO, 18, LO);
    idle(GAP);
    check("partial_words",    64'(q_words.size()), 64'd0);
    check("partial_len",      64'(len_at(0)),      64'd0);
    check("partial_err",      64'(n_err),          64'd1);
    check("partial_err_done", 64'(n_err_done),     64'd1);
    clear_logs();
    send_bits(24'h123456, 23, 24, 35, LO, 18, LO);
    idle(GAP);
    check("after_partial_word", 64'(word_at(0)), 64'h123456);
    check("after_partial_idx",  64'(idx_at(0)),  64'd0);
    check("after_partial_len",  64'(len_at(0)),  64'd1);

    // Glitch mid-word: skipped, the word completes one pulse later.
    clear_logs();
    send_bits(24'h5A5A5A, 23, 12, 35, LO, 18, LO);
    pulse(3, 10);
    send_bits(24'h5A5A5A, 11, 12, 35, LO, 18, LO);
    idle(GAP);
    check("glitch_count", 64'(q_words.size()), 64'd1);
    check("glitch_word",  64'(word_at(0)),     64'h5A5A5A);
    check("glitch_err",   64'(n_err),          64'd1);
    check("glitch_len",   64'(len_at(0)),      64'd1);

    // Stuck high drops the 5 bits in flight; decoding resumes after the fall.
    clear_logs();
    send_bits(24'hFFFFFF, 23, 5, 35, LO, 18, LO);
    pulse(100, 10);
    send_bits(24'h0F0F0F, 23, 24, 35, LO, 18, LO);
    idle(GAP);
    check("stuck_count",    64'(q_words.size()), 64'd1);
    check("stuck_word",     64'(word_at(0)),     64'h0F0F0F);
    check("stuck_idx",      64'(idx_at(0)),      64'd0);
    check("stuck_err",      64'(n_err),          64'd1);
    check("stuck_err_done", 64'(n_err_done),     64'd0);
    check("stuck_len",      64'(len_at(0)),      64'd1);
    check("stuck_model",    64'(mdl_last()),     64'h0F0F0F);

    // Low gap of T_RST-1 inside a word keeps decoding.
    clear_logs();
    send_bits(24'hC3C3C3, 23, 12, 35, LO, 18, LO);
    idle(T_RST - 1 - LO);
    send_bits(24'hC3C3C3, 11, 12, 35, LO, 18, LO);
    idle(GAP);
    check("gap2499_frames", 64'(q_lens.size()), 64'd1);
    check("gap2499_len",    64'(len_at(0)),     64'd1);
    check("gap2499_word",   64'(word_at(0)),    64'hC3C3C3);

    // Low gap of exactly T_RST ends the frame; next pulse starts a new one.
    clear_logs();
    send_bits(24'hA5A5A5, 23, 24, 35, LO, 18, LO);
    idle(T_RST - LO);
    send_bits(24'h3C3C3C, 23, 24, 35, LO, 18, LO);
    idle(GAP);
    check("gap2500_frames", 64'(q_lens.size()), 64'd2);
    check("gap2500_len0",   64'(len_at(0)),     64'd1);
    check("gap2500_len1",   64'(len_at(1)),     64'd1);
    check("gap2500_word1",  64'(word_at(1)),    64'h3C3C3C);
    check("gap2500_idx1",   64'(idx_at(1)),     64'd0);
    check("gap2500_err",    64'(n_err),         64'd0);

    // Reset after 12 bits discards everything.
    clear_logs();
    send_bits(24'hE1E1E1, 23, 12, 35, LO, 18, LO);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    idle(10);
    send_bits(24'h765432, 23, 24, 35, LO, 18, LO);
    idle(GAP);
    check("midrst_count", 64'(q_words.size()), 64'd1);
    check("midrst_word",  64'(word_at(0)),     64'h765432);
    check("midrst_idx",   64'(idx_at(0)),      64'd0);
    check("midrst_len",   64'(len_at(0)),      64'd1);
    check("midrst_err",   64'(n_err),          64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
